output_readback_dma: RTL

//  Streams a contiguous block of results out of output_memory after an engine run.

---
 rtl/swin_mem_pkg.sv | 13 +
 rtl/rdma_sync_fifo.sv | 58 +++++
 rtl/output_readback_dma.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/swin_mem_pkg.sv
// Shared definitions for the output memory and its readback DMA.
package swin_mem_pkg;

  localparam int OUT_MEM_DEPTH = 301056;
  localparam int OUT_MEM_AW    = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rdma_state_e;

endpackage

// File: rtl/rdma_sync_fifo.sv
// Small synchronous FIFO with occupancy count and synchronous flush.
// The head entry is presented combinationally; flush wins over push and pop.
module rdma_sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/output_readback_dma.sv
// Streams a contiguous block of output_memory words onto a valid/ready stream.
// Reads are issued only against free FIFO credit, so every returning word has a slot.
module output_readback_dma
  import swin_mem_pkg::*;
#(
  parameter int AW         = OUT_MEM_AW,
  parameter int DEPTH      = OUT_MEM_DEPTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   num_words,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] rd_addr,
  output logic          rd_en,
  input  logic [31:0]   rd_data,
  output logic          m_valid,
  output logic [31:0]   m_data,
  output logic          m_last,
  input  logic          m_ready
);

  // Stream handshake: a beat transfers on a rising clk edge where m_valid && m_ready;
  // once m_valid rises, m_data/m_last hold until that transfer (or an abort flush).

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rdma_state_e   state_q, state_d;
  logic [AW-1:0] base_q;
  logic [AW:0]   num_q;
  logic [AW:0]   issued_q;
  logic [AW:0]   pushed_q;
  logic          inflight_q;
  logic          done_q;
  logic          err_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [32:0]   fifo_head;
  logic          push;
  logic          pop;
  logic          push_last;
  logic [CW:0]   occupancy;
  logic          credit_ok;
  logic [AW+1:0] end_addr;
  logic          range_bad;
  logic          accept_start;

  assign end_addr     = {2'b00, base_addr} + {1'b0, num_words};
  assign range_bad    = end_addr > (AW+2)'(DEPTH);
  assign accept_start = (state_q == IDLE) && start && !abort;

  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);

  assign push      = inflight_q && !abort;
  assign push_last = (pushed_q == num_q - (AW+1)'(1));

  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? fifo_head[31:0] : 32'd0;
  assign m_last  = m_valid && fifo_head[32];
  assign pop     = m_valid && m_ready;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_start && (num_words != '0) && !range_bad) state_d = RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if ((issued_q < num_q) && credit_ok) begin
          rd_en = 1'b1;
          if (issued_q == num_q - (AW+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) state_d = IDLE;
        else if (pop && m_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_addr = rd_en ? (base_q + issued_q[AW-1:0]) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      pushed_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      if (accept_start) begin
        if (num_words == '0) begin
          done_q <= 1'b1;
        end else if (range_bad) begin
          err_q <= 1'b1;
        end else begin
          base_q   <= base_addr;
          num_q    <= num_words;
          issued_q <= '0;
          pushed_q <= '0;
        end
      end
      if (rd_en) issued_q <= issued_q + (AW+1)'(1);
      if (push)  pushed_q <= pushed_q + (AW+1)'(1);
      if ((state_q == DRAIN) && (state_d == IDLE) && !abort) done_q <= 1'b1;
    end
  end

  rdma_sync_fifo #(
    .W     (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (push),
    .push_data ({push_last, rd_data}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule
